// File: rtl/sqw_meas_ctrl.sv
// Square-wave half-period monitor: measures the time between edges (or times out),
// classifies each half-period against a band and debounces the result into OK/FAULT.
module sqw_meas_ctrl #(
  parameter int CNT_W     = 20,
  parameter int MIN_HALF  = 24000,
  parameter int MAX_HALF  = 36000,
  parameter int FAULT_CNT = 3,
  parameter int GOOD_CNT  = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             isquareWave,
  output logic             oState_n,
  output logic             oValid,
  output logic [CNT_W-1:0] oHalfLen,
  output logic             oTimeout
);

  localparam int RUN_W = 8;
  localparam logic [CNT_W-1:0] TMO_LEN   = CNT_W'(MAX_HALF + 1);
  localparam logic [CNT_W-1:0] MIN_LEN   = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] MAX_LEN   = CNT_W'(MAX_HALF);
  localparam logic [RUN_W-1:0] FAULT_LIM = RUN_W'(FAULT_CNT);
  localparam logic [RUN_W-1:0] GOOD_LIM  = RUN_W'(GOOD_CNT);

  typedef enum logic [1:0] {IDLE, ARM, RUN_OK, RUN_FAULT} state_e;

  state_e           state_q, state_d;
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] bad_q, bad_d, good_q, good_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             tmo_q, tmo_d;

  logic             edge_det, tmo_hit, meas, len_good;
  logic [RUN_W-1:0] bad_inc, good_inc;

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the edge-detect history
  assign edge_det = sync_q[1] ^ sync_q[2];
  assign tmo_hit  = (cnt_q == TMO_LEN);
  assign meas     = edge_det | tmo_hit;
  // A timeout leaves cnt_q at MAX_HALF+1, so it always lands out of band
  assign len_good = (cnt_q >= MIN_LEN) && (cnt_q <= MAX_LEN);
  assign bad_inc  = (&bad_q)  ? bad_q  : bad_q + 1'b1;
  assign good_inc = (&good_q) ? good_q : good_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    good_d  = good_q;
    valid_d = 1'b0;
    len_d   = len_q;
    tmo_d   = tmo_q;
    if (!iEn) begin
      state_d = IDLE;
      cnt_d   = '0;
      bad_d   = '0;
      good_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
        end
        ARM: begin
          if (meas) begin
            state_d = RUN_OK;
            cnt_d   = CNT_W'(1);
            if (!edge_det) begin
              valid_d = 1'b1;
              len_d   = cnt_q;
              tmo_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN_OK, RUN_FAULT: begin
          if (meas) begin
            valid_d = 1'b1;
            len_d   = cnt_q;
            tmo_d   = ~edge_det;
            cnt_d   = CNT_W'(1);
            if (state_q == RUN_OK) begin
              if (len_good) begin
                bad_d = '0;
              end else if (bad_inc >= FAULT_LIM) begin
                state_d = RUN_FAULT;
                bad_d   = '0;
                good_d  = '0;
              end else begin
                bad_d = bad_inc;
              end
            end else begin
              if (!len_good) begin
                good_d = '0;
              end else if (good_inc >= GOOD_LIM) begin
                state_d = RUN_OK;
                bad_d   = '0;
                good_d  = '0;
              end else begin
                good_d = good_inc;
              end
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      cnt_q   <= '0;
      bad_q   <= '0;
      good_q  <= '0;
      valid_q <= 1'b0;
      len_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], isquareWave};
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      good_q  <= good_d;
      valid_q <= valid_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
    end
  end

  assign oState_n = (state_q != RUN_FAULT);
  assign oValid   = valid_q;
  assign oHalfLen = len_q;
  assign oTimeout = tmo_q;

endmodule

// File: tb/tb_sqw_meas_ctrl.sv
// Bench for sqw_meas_ctrl with a scaled-down band (240..360 cycles, nominal 300, short 60);
// expected measurements come from an event-level model of the transition times.
module tb_sqw_meas_ctrl;

  localparam int CW   = 12;
  localparam int MINH = 240;
  localparam int MAXH = 360;
  localparam int M1   = MAXH + 1;
  localparam int FCNT = 3;
  localparam int GCNT = 4;

  logic          clk, rst, en, sq;
  logic          state_n, valid, tmo;
  logic [CW-1:0] half_len;

  sqw_meas_ctrl #(
    .CNT_W(CW), .MIN_HALF(MINH), .MAX_HALF(MAXH), .FAULT_CNT(FCNT), .GOOD_CNT(GCNT)
  ) dut (
    .iClk(clk), .iRst(rst), .iEn(en), .isquareWave(sq),
    .oState_n(state_n), .oValid(valid), .oHalfLen(half_len), .oTimeout(tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int t; int len; bit tmo; bit st;} ev_t;
  ev_t dut_q[$];
  ev_t exp_q[$];
  int  det_q[$];

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      ev_t e;
      e.t = cyc; e.len = int'(half_len); e.tmo = tmo; e.st = state_n;
      dut_q.push_back(e);
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model: transition detection times, OK/FAULT flag and streak length
  int last_t, streak, exp_len;
  bit armed, fault;

  function automatic void push_meas(int t, int len, bit to, bit from_arm);
    ev_t e;
    bit good;
    good = !to && len >= MINH && len <= MAXH;
    if (!from_arm) begin
      if (good != !fault) begin
        streak++;
        if (streak == (fault ? GCNT : FCNT)) begin
          fault  = !fault;
          streak = 0;
        end
      end else begin
        streak = 0;
      end
    end
    e.t = t; e.len = len; e.tmo = to; e.st = !fault;
    exp_q.push_back(e);
    exp_len = len;
  endfunction

  function automatic void model_run(int h);
    int nd;
    bit busy;
    busy = 1'b1;
    while (busy) begin
      nd = (det_q.size() != 0) ? det_q[0] : 32'h3fff_ffff;
      if (nd - last_t > M1 && last_t + M1 <= h) begin
        push_meas(last_t + M1, M1, 1'b1, !armed);
        armed  = 1'b1;
        last_t = last_t + M1;
      end else if (det_q.size() != 0 && nd <= h) begin
        void'(det_q.pop_front());
        if (armed) push_meas(nd, nd - last_t, 1'b0, 1'b0);
        armed  = 1'b1;
        last_t = nd;
      end else begin
        busy = 1'b0;
      end
    end
  endfunction

  // Enable seen at the next edge puts the DUT in ARM, whose timeout base is one cycle later
  function automatic void model_reset(int e);
    det_q.delete();
    armed  = 1'b0;
    fault  = 1'b0;
    streak = 0;
    last_t = e + 2;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle();
    sq = ~sq;
    det_q.push_back(cyc + 3);
  endtask

  task automatic drive_halves(input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(hi, lo));
      toggle();
    end
  endtask

  task automatic compare_upto(input string tag);
    int h;
    ev_t e, a;
    h = cyc - 1;
    model_run(h);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (dut_q.size() == 0 || dut_q[0].t > h) begin
        errors++;
        $display("FAIL %s missing_valid: got none, need t=%0d len=%0d tmo=%0d st=%0d",
                 tag, e.t, e.len, e.tmo, e.st);
      end else begin
        a = dut_q.pop_front();
        if (a.t != e.t || a.len != e.len || a.tmo != e.tmo || a.st != e.st) begin
          errors++;
          $display("FAIL %s valid: got t=%0d len=%0d tmo=%0d st=%0d, need t=%0d len=%0d tmo=%0d st=%0d",
                   tag, a.t, a.len, a.tmo, a.st, e.t, e.len, e.tmo, e.st);
        end else begin
          $display("%s t=%0d len=%0d tmo=%0d st=%0d ok", tag, a.t, a.len, a.tmo, a.st);
        end
      end
    end
    checks++;
    if (dut_q.size() != 0 && dut_q[0].t <= h) begin
      errors++;
      $display("FAIL %s extra_valid: got t=%0d len=%0d, need none", tag, dut_q[0].t, dut_q[0].len);
      while (dut_q.size() != 0 && dut_q[0].t <= h) void'(dut_q.pop_front());
    end
    checks++;
    if (state_n !== !fault) begin
      errors++;
      $display("FAIL %s state_n: got %b, need %b", tag, state_n, !fault);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sq = 1'b0;
    step(5);
    checks += 4;
    if (state_n !== 1'b1) begin errors++; $display("FAIL reset state_n: got %b, need 1", state_n); end
    if (valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b, need 0", valid); end
    if (half_len !== '0) begin errors++; $display("FAIL reset half_len: got %0d, need 0", half_len); end
    if (tmo !== 1'b0) begin errors++; $display("FAIL reset timeout: got %b, need 0", tmo); end
    $display("reset checked");
  endtask

  task automatic test_nominal();
    rst = 1'b0;
    model_reset(cyc);
    exp_len = 0;
    step(10);
    toggle();
    step(6);
    checks++;
    if (dut_q.size() != 0) begin
      errors++;
      $display("FAIL first_edge: got %0d valid pulses, need 0", dut_q.size());
    end
    drive_halves(8, 299, 301);
    step(5);
    compare_upto("nominal");
  endtask

  task automatic test_short();
    drive_halves(5, 59, 61);
    step(5);
    compare_upto("short");
    checks++;
    if (state_n !== 1'b0) begin errors++; $display("FAIL short_fault: got %b, need 0", state_n); end
  endtask

  task automatic test_recovery();
    drive_halves(2, 299, 301);
    drive_halves(1, 59, 61);
    drive_halves(4, 299, 301);
    step(5);
    compare_upto("recovery");
  endtask

  task automatic test_stuck();
    step(3 * M1 + 40);
    compare_upto("stuck");
    checks++;
    if (half_len !== CW'(M1) || tmo !== 1'b1) begin
      errors++;
      $display("FAIL stuck_hold: got len=%0d tmo=%b, need len=%0d tmo=1", half_len, tmo, M1);
    end
  endtask

  task automatic test_abort_en();
    en = 1'b0;
    model_run(cyc);
    step(1);
    checks++;
    if (state_n !== 1'b1 || valid !== 1'b0 || half_len !== CW'(exp_len)) begin
      errors++;
      $display("FAIL abort_en: got st=%b valid=%b len=%0d, need st=1 valid=0 len=%0d",
               state_n, valid, half_len, exp_len);
    end
    en = 1'b1;
    model_reset(cyc);
    step(20);
    toggle();
    drive_halves(2, 299, 301);
    drive_halves(4, 59, 61);
    step(100);
    compare_upto("rearm");
  endtask

  task automatic test_abort_rst();
    rst = 1'b1;
    model_run(cyc);
    step(1);
    checks++;
    if (state_n !== 1'b1 || valid !== 1'b0 || half_len !== '0 || tmo !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst: got st=%b valid=%b len=%0d tmo=%b, need st=1 valid=0 len=0 tmo=0",
               state_n, valid, half_len, tmo);
    end
    rst = 1'b0;
    model_reset(cyc);
    exp_len = 0;
    // Clearing the synchroniser while the input is high looks like an edge afterwards
    if (sq) det_q.push_back(cyc + 3);
    drive_halves(5, 299, 301);
    step(5);
    compare_upto("after_rst");
  endtask

  task automatic test_boundary();
    int gaps [9] = '{MINH, MAXH, MINH - 1, M1, M1 + 1, 300, 300, 300, 300};
    for (int i = 0; i < 9; i++) begin
      step(gaps[i]);
      toggle();
    end
    step(5);
    compare_upto("boundary");
  endtask

  task automatic test_arm_timeout();
    en = 1'b0;
    model_run(cyc);
    step(1);
    en = 1'b1;
    model_reset(cyc);
    step(M1 + 30);
    toggle();
    drive_halves(3, 299, 301);
    step(5);
    compare_upto("arm_timeout");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short();
    test_recovery();
    test_stuck();
    test_abort_en();
    test_abort_rst();
    test_boundary();
    test_arm_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
